// File: rtl/key_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states,
// column reset pattern and the (column,row) -> key code map.
package key_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } key_state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Keypad legend: columns 0..2 form the 1-9 grid plus A/B/C; column 3 is F,0,E,D.
  function automatic logic [3:0] key_code_of(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    code = 4'h0;
    case ({col, row})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h7;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h8;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hF;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hE;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    case (cols)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Lowest active-low row wins when several keys share the driven column.
  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/key_scan_tick.sv
// Free-running scan-rate divider: one-cycle tick every SCAN_DIV clocks.
module key_scan_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic Clk,
  input  logic Rst,
  output logic tick
);

  localparam int W = $clog2(SCAN_DIV);
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] div;

  always_ff @(posedge Clk) begin
    if (Rst)              div <= '0;
    else if (div == LAST) div <= '0;
    else                  div <= div + 1'b1;
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad controller: column scan, row sync, press/release debounce and a
// one-entry valid/ready output buffer delivering one code per physical press.
module key_scan_ctrl
  import key_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] key_r,
  output logic [3:0] key_c,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overrun
);

  localparam int CW = $clog2(DEBOUNCE_N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(DEBOUNCE_N);

  logic          tick;
  logic [3:0]    rs_meta, rs;
  key_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [3:0]    key_c_nx;
  logic [1:0]    col_q, row_q, col_nx, row_nx;
  logic          confirm;
  logic [3:0]    confirm_code;

  key_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .Clk  (Clk),
    .Rst  (Rst),
    .tick (tick)
  );

  assign cnt_inc      = cnt + 1'b1;
  assign confirm_code = key_code_of(col_nx, row_nx);
  assign key_down     = (state == ST_HELD);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    key_c_nx = key_c;
    col_nx   = col_q;
    row_nx   = row_q;
    confirm  = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (rs == 4'hF) begin
            key_c_nx = {key_c[2:0], key_c[3]};
          end else begin
            col_nx = col_index(key_c);
            row_nx = row_index(rs);
            // A single-sample debounce confirms on the very tick that first sees the row.
            if (DEBOUNCE_N == 1) begin
              confirm  = 1'b1;
              state_nx = ST_HELD;
              cnt_nx   = '0;
            end else begin
              state_nx = ST_DEBOUNCE;
              cnt_nx   = CW'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!rs[row_q]) begin
            if (cnt_inc == N_CNT) begin
              confirm  = 1'b1;
              state_nx = ST_HELD;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            state_nx = ST_SCAN;
            cnt_nx   = '0;
          end
        end
        ST_HELD: begin
          if (rs[row_q]) begin
            if (cnt_inc == N_CNT) begin
              state_nx = ST_SCAN;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            cnt_nx = '0;
          end
        end
        default: begin
          state_nx = ST_SCAN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rs_meta   <= '1;
      rs        <= '1;
      state     <= ST_SCAN;
      cnt       <= '0;
      key_c     <= COL_RESET;
      col_q     <= '0;
      row_q     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rs_meta <= key_r;
      rs      <= rs_meta;
      state   <= state_nx;
      cnt     <= cnt_nx;
      key_c   <= key_c_nx;
      col_q   <= col_nx;
      row_q   <= row_nx;
      overrun <= 1'b0;
      // A confirm may refill the buffer in the same cycle it drains.
      if (confirm) begin
        if (!key_valid || key_ready) begin
          key_code  <= confirm_code;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule
